// File: rtl/freg_wb_arbiter_pkg.sv
// freg_wb_arbiter_pkg: shared constants and types for the FP register
// file write-back arbiter and its scoreboard.
package freg_wb_arbiter_pkg;

   localparam int FWB_NREQ = 3;
   localparam int FREG_AW  = 5;
   localparam int FREG_DW  = 32;

   localparam int FWB_LOAD = 0;
   localparam int FWB_FPU  = 1;
   localparam int FWB_MOVE = 2;

   typedef struct packed {
      logic [FREG_AW-1:0] rd;
      logic [FREG_DW-1:0] data;
   } freg_wr_t;

endpackage

// File: rtl/freg_wb_arbiter_if.sv
// freg_wb_arbiter_if: requester, issue and register-file-side signals of
// the FP write-back arbiter. slave = arbiter, master = producers/pipeline.
interface freg_wb_arbiter_if
   import freg_wb_arbiter_pkg::*;
#(
   parameter int NREQ = FWB_NREQ,
   parameter int DW   = FREG_DW,
   parameter int AW   = FREG_AW
);

   logic [NREQ-1:0]    iReqValid;
   logic [NREQ*AW-1:0] iReqRd;
   logic [NREQ*DW-1:0] iReqData;
   logic [NREQ-1:0]    oReqReady;
   logic               iIssueValid;
   logic [AW-1:0]      iIssueRd;
   logic               iFlush;
   logic               oRegWrite;
   logic [AW-1:0]      oWriteRegister;
   logic [DW-1:0]      oWriteData;
   logic [2**AW-1:0]   oBusy;

   modport slave (
      input  iReqValid, iReqRd, iReqData,
      input  iIssueValid, iIssueRd, iFlush,
      output oReqReady, oRegWrite,
      output oWriteRegister, oWriteData, oBusy
   );

   modport master (
      output iReqValid, iReqRd, iReqData,
      output iIssueValid, iIssueRd, iFlush,
      input  oReqReady, oRegWrite,
      input  oWriteRegister, oWriteData, oBusy
   );

endinterface

// File: rtl/freg_scoreboard.sv
// freg_scoreboard: pending-write bit per FP register. Ports: iCLK, iRST
// (async, active-high), set_en/set_rd, clr_en/clr_rd, flush, busy.
module freg_scoreboard
   import freg_wb_arbiter_pkg::*;
#(
   parameter int AW = FREG_AW
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             set_en,
   input  logic [AW-1:0]    set_rd,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_rd,
   input  logic             flush,
   output logic [2**AW-1:0] busy
);

   logic [2**AW-1:0] busy_nxt;

   // clear first so a same-register set overrides it
   always_comb begin
      busy_nxt = busy;
      if (clr_en)
         busy_nxt[clr_rd] = 1'b0;
      if (set_en)
         busy_nxt[set_rd] = 1'b1;
      if (flush)
         busy_nxt = '0;
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: rtl/freg_wb_arbiter.sv
// freg_wb_arbiter: shares the FP register file write port among load,
// FPU and int-move producers; registers the winner one cycle and keeps
// the pending-write scoreboard.
// Ports: iCLK, iRST (async, active-high), bus (freg_wb_arbiter_if.slave).
// Build option FREG_ARB_RR_EN: round-robin instead of fixed priority.
module freg_wb_arbiter
   import freg_wb_arbiter_pkg::*;
#(
   parameter int NREQ = FWB_NREQ,
   parameter int DW   = FREG_DW,
   parameter int AW   = FREG_AW
) (
   input logic                iCLK,
   input logic                iRST,
   freg_wb_arbiter_if.slave   bus
);

   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] ready;
   logic            xfer;
   logic [AW-1:0]   wr_rd;
   logic [DW-1:0]   wr_data;

`ifdef FREG_ARB_RR_EN
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   int            idx;

   // first valid requester at or after ptr, wrapping
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      idx     = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (grant == '0 && bus.iReqValid[idx]) begin
            grant[idx] = 1'b1;
            ptr_nxt    = PW'((idx + 1) % NREQ);
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         ptr <= '0;
      else if (xfer)
         ptr <= ptr_nxt;
   end
`else
   // lowest index wins: load > FPU > int-move
   always_comb begin
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == '0 && bus.iReqValid[i])
            grant[i] = 1'b1;
      end
   end
`endif

   assign ready         = iRST ? '0 : grant;
   assign bus.oReqReady = ready;
   assign xfer          = |ready;

   always_comb begin
      wr_rd   = '0;
      wr_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ready[i]) begin
            wr_rd   = bus.iReqRd[i*AW +: AW];
            wr_data = bus.iReqData[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         bus.oRegWrite      <= 1'b0;
         bus.oWriteRegister <= '0;
         bus.oWriteData     <= '0;
      end else begin
         bus.oRegWrite <= xfer;
         if (xfer) begin
            bus.oWriteRegister <= wr_rd;
            bus.oWriteData     <= wr_data;
         end
      end
   end

   freg_scoreboard #(.AW(AW)) u_sb (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .set_en (bus.iIssueValid),
      .set_rd (bus.iIssueRd),
      .clr_en (xfer),
      .clr_rd (wr_rd),
      .flush  (bus.iFlush),
      .busy   (bus.oBusy)
   );

endmodule

// File: doc/freg_wb_arbiter.md
Name: freg_wb_arbiter

Overview:
Shares the single write port of the 32x32 FP register file among three producers:
- FP load unit (FLW)
- multicycle FPU
- integer-to-FP move/convert path (FMV.W.X / FCVT.S.W)

Registers the winning write for one cycle and drives the register file write port. Keeps a 32-bit pending-write scoreboard so the hazard unit can stall readers of FP registers with in-flight results.

Parameters:
NREQ, 3, number of write requesters (fixed index map: 0 = load, 1 = FPU, 2 = int-move)
DW, 32, data width
AW, 5, register address width

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
iReqValid  in  NREQ  per-requester write request
iReqRd  in  NREQ*AW  per-requester destination register, requester k in bits [k*AW +: AW]
iReqData  in  NREQ*DW  per-requester write data, packed as above
oReqReady  out  NREQ  grant/accept, one-hot or zero
iIssueValid  in  1  an FP-writing instruction issues this cycle
iIssueRd  in  AW  its destination register
iFlush  in  1  pipeline flush: clears scoreboard, not the output stage
oRegWrite  out  1  to register file write enable
oWriteRegister  out  AW  to register file write address
oWriteData  out  DW  to register file write data
oBusy  out  32  scoreboard, bit r = write to fr pending

Behaviour:
- Reset (async): oRegWrite=0, oWriteRegister=0, oWriteData=0, oBusy=0, oReqReady=0, round-robin pointer=0.
- Handshake: transfer when iReqValid[k] & oReqReady[k].
  - oReqReady is combinational from iReqValid and the priority state.
  - At most one bit of oReqReady is set; it is set only when the matching iReqValid is high.
  - A requester holds valid/rd/data stable until accepted.
  - oReqReady is 0 while iRST is high.
- Arbitration (default fixed priority): load > FPU > int-move.
- Output stage: on transfer, next edge oRegWrite=1, oWriteRegister=rd, oWriteData=data. With no transfer, next edge oRegWrite=0; address and data hold their last values.
  - Latency: transfer edge to register file write = 1 cycle.
  - Throughput: 1 write per cycle.
- fr0 is an ordinary register; writes to rd=0 are not suppressed.
- Scoreboard, evaluated per edge:
  - set bit iIssueRd if iIssueValid;
  - clear bit rd of the accepted transfer;
  - if both target the same register in one cycle, set wins (new producer in flight).
  - iFlush forces oBusy=0 that edge, overriding set and clear.
  - A transfer accepted during a flush still writes the register file.
- Clearing an already-clear bit is legal and has no effect. A duplicate issue to a busy register keeps it busy; the first completing write clears it. The in-order issue unit prevents WAW to a busy register.
- Reset mid-transfer: the pending output write is dropped and oRegWrite goes 0 immediately (async).

Optional Feature:
FREG_ARB_RR_EN
- Defined: round-robin arbitration.
  - Search starts at the pointer, in index order with wrap-around.
  - After a grant to k, the pointer moves to (k+1) mod NREQ.
  - The pointer is unchanged when nothing is granted.
  - Guarantees every requester is served within NREQ cycles of asserting valid.
- Undefined: fixed priority as above; no pointer register is instantiated.

Decomposition:
- Shared package holds:
  - requester index constants FWB_LOAD=0, FWB_FPU=1, FWB_MOVE=2;
  - FREG_AW=5, FREG_DW=32, FWB_NREQ=3.
- One natural sub-module: freg_scoreboard (32-bit set/clear/flush register, set-wins rule), reusable by a future FP forwarding unit.
- Arbitration logic stays inline.

Test Plan:
- Reset release, single load request rd=5 data=32'h3F800000 → oReqReady=3'b001 same cycle; next cycle oRegWrite=1, oWriteRegister=5, oWriteData=32'h3F800000; following cycle oRegWrite=0.
- All three valid every cycle, fixed priority → load granted every cycle, FPU/move never granted. With FREG_ARB_RR_EN: grants 0,1,2,0,1,2.
- Issue rd=7 → oBusy[7]=1 next cycle; FPU completes rd=7 three cycles later → oBusy[7]=0 one cycle after the transfer.
- Same-cycle iIssueValid rd=9 and int-move transfer rd=9 → oBusy[9]=1 after the edge, and register file write to 9 occurs.
- oBusy=32'h00000410 with iFlush and a load transfer rd=4 in one cycle → oBusy=0, and the write to fr4 still occurs next cycle.
- iRST asserted asynchronously while oRegWrite=1 → oRegWrite=0 before the next clock; after release, all outputs are at their reset values.
